// File: rtl/registro_banco_if.sv
// Register bank bus: write-back port, two read ports and the debug dump
// stream. master drives requests (pipeline/debug side), slave is the bank.
interface registro_banco_if #(
    parameter int NBITS = 32,
    parameter int RBITS = 5
);
    logic             i_RegWrite;
    logic [RBITS-1:0] i_WriteReg;
    logic [NBITS-1:0] i_WriteData;
    logic [RBITS-1:0] i_rs;
    logic [RBITS-1:0] i_rt;
    logic [NBITS-1:0] o_ReadData1;
    logic [NBITS-1:0] o_ReadData2;
    logic             i_DumpStart;
    logic             i_DumpReady;
    logic             o_DumpValid;
    logic [RBITS-1:0] o_DumpAddr;
    logic [NBITS-1:0] o_DumpData;
    logic             o_DumpBusy;
    logic             o_DumpDone;

    modport master (
        output i_RegWrite, i_WriteReg, i_WriteData, i_rs, i_rt,
        output i_DumpStart, i_DumpReady,
        input  o_ReadData1, o_ReadData2,
        input  o_DumpValid, o_DumpAddr, o_DumpData, o_DumpBusy, o_DumpDone
    );

    modport slave (
        input  i_RegWrite, i_WriteReg, i_WriteData, i_rs, i_rt,
        input  i_DumpStart, i_DumpReady,
        output o_ReadData1, o_ReadData2,
        output o_DumpValid, o_DumpAddr, o_DumpData, o_DumpBusy, o_DumpDone
    );
endinterface

// File: rtl/registro_banco.sv
// MIPS register file: one write port, two bypassed read ports and a
// handshaked sequential dump of every register for the debug unit.
module registro_banco #(
    parameter int NBITS = 32,
    parameter int RBITS = 5,
    parameter int NREGS = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    registro_banco_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    logic [NBITS-1:0] regs [NREGS];
    logic             wr_en;
    logic             hit1;
    logic             hit2;
    dump_state_t      state;
    logic [RBITS-1:0] ptr;

    // r0 is never written, so it reads 0 without a special case
    assign wr_en = bus.i_RegWrite && (bus.i_WriteReg != '0);
    assign hit1  = wr_en && (bus.i_WriteReg == bus.i_rs);
    assign hit2  = wr_en && (bus.i_WriteReg == bus.i_rt);

    assign bus.o_ReadData1 = hit1 ? bus.i_WriteData : regs[bus.i_rs];
    assign bus.o_ReadData2 = hit2 ? bus.i_WriteData : regs[bus.i_rt];

    // Register storage with write-back update
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.i_WriteReg] <= bus.i_WriteData;
        end
    end

    // Dump sequencer; LOAD samples the stored value, so a write on
    // the same edge is not seen, and SEND holds the word frozen
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            ptr             <= '0;
            bus.o_DumpValid <= 1'b0;
            bus.o_DumpAddr  <= '0;
            bus.o_DumpData  <= '0;
            bus.o_DumpBusy  <= 1'b0;
            bus.o_DumpDone  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.o_DumpDone <= 1'b0;
                    if (bus.i_DumpStart) begin
                        ptr            <= '0;
                        bus.o_DumpBusy <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    bus.o_DumpAddr  <= ptr;
                    bus.o_DumpData  <= regs[ptr];
                    bus.o_DumpValid <= 1'b1;
                    state           <= SEND;
                end
                SEND: begin
                    if (bus.i_DumpReady) begin
                        bus.o_DumpValid <= 1'b0;
                        if (ptr == RBITS'(NREGS - 1)) begin
                            bus.o_DumpDone <= 1'b1;
                            state          <= DONE;
                        end else begin
                            ptr   <= ptr + RBITS'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    bus.o_DumpDone <= 1'b0;
                    bus.o_DumpBusy <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_registro_banco.sv
// Testbench for registro_banco: reference register array plus dump
// tracker checked every cycle, and directed scenarios with literals.
module tb_registro_banco;

    logic clk;
    logic rst;

    registro_banco_if #(.NBITS(32), .RBITS(5)) bus ();

    registro_banco #(.NBITS(32), .RBITS(5), .NREGS(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [32];
    logic [31:0] snap  [32];
    int          exp_idx = 0;
    logic        pv = 1'b0;
    logic [31:0] exp_held = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_exp(input logic [4:0] a);
        if (bus.i_RegWrite && bus.i_WriteReg != 0 && bus.i_WriteReg == a)
            return bus.i_WriteData;
        return model[a];
    endfunction

    // Per-cycle compare against the reference model
    initial begin
        for (int i = 0; i < 32; i++) begin
            model[i] = '0;
            snap[i]  = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 32; i++) model[i] = '0;
                exp_idx = 0;
                pv      = 1'b0;
                chk("rst_valid", 32'(bus.o_DumpValid), 0);
                chk("rst_busy",  32'(bus.o_DumpBusy), 0);
                chk("rst_done",  32'(bus.o_DumpDone), 0);
                chk("rst_data",  bus.o_DumpData, 0);
            end
            chk("rd1", bus.o_ReadData1, rd_exp(bus.i_rs));
            chk("rd2", bus.o_ReadData2, rd_exp(bus.i_rt));
            if (bus.o_DumpValid) begin
                if (!pv) exp_held = snap[exp_idx];
                chk("dump_addr", 32'(bus.o_DumpAddr), 32'(exp_idx));
                chk("dump_data", bus.o_DumpData, exp_held);
            end
            pv = bus.o_DumpValid;
            if (bus.o_DumpValid && bus.i_DumpReady) exp_idx++;
            if (bus.o_DumpDone) exp_idx = 0;
            @(posedge clk);
            snap = model;
            if (!rst && bus.i_RegWrite && bus.i_WriteReg != 0)
                model[bus.i_WriteReg] = bus.i_WriteData;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        bus.i_RegWrite  = 1'b1;
        bus.i_WriteReg  = a;
        bus.i_WriteData = d;
        tick();
        bus.i_RegWrite  = 1'b0;
    endtask

    // Wait until a word with the given address is presented
    task automatic wait_addr(input logic [4:0] a, output logic found);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            tick();
            bus.i_DumpStart = 1'b0;
            if (bus.o_DumpValid && bus.o_DumpAddr == a) found = 1'b1;
        end
    endtask

    task automatic wait_done(output logic found);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            tick();
            bus.i_DumpStart = 1'b0;
            if (bus.o_DumpDone) found = 1'b1;
        end
    endtask

    int          fv;
    int          dn;
    int          dc;
    int          words;
    logic [31:0] d31;
    logic        found;

    initial begin
        rst             = 1'b1;
        bus.i_RegWrite  = 1'b0;
        bus.i_WriteReg  = '0;
        bus.i_WriteData = '0;
        bus.i_rs        = '0;
        bus.i_rt        = '0;
        bus.i_DumpStart = 1'b0;
        bus.i_DumpReady = 1'b0;

        // Reset: every address reads 0 on both ports
        for (int i = 0; i < 32; i++) begin
            bus.i_rs = 5'(i);
            bus.i_rt = 5'(31 - i);
            tick();
        end
        chk("rst_rd1_lit", bus.o_ReadData1, 0);
        chk("rst_addr_lit", 32'(bus.o_DumpAddr), 0);
        rst = 1'b0;
        tick();

        // Plain write/read and r0 discard
        wr_reg(5'd8, 32'hDEADBEEF);
        bus.i_rs = 5'd8;
        #1 chk("r8_lit", bus.o_ReadData1, 32'hDEADBEEF);
        wr_reg(5'd0, 32'h12345678);
        bus.i_rt = 5'd0;
        #1 chk("r0_lit", bus.o_ReadData2, 0);

        // Same-cycle bypass
        bus.i_RegWrite  = 1'b1;
        bus.i_WriteReg  = 5'd9;
        bus.i_WriteData = 32'hA5A5A5A5;
        bus.i_rs        = 5'd9;
        #1 chk("bypass_lit", bus.o_ReadData1, 32'hA5A5A5A5);
        tick();
        bus.i_RegWrite = 1'b0;
        #1 chk("r9_lit", bus.o_ReadData1, 32'hA5A5A5A5);

        // Preload r_k = k*0x11, then full dump with ready high
        for (int k = 0; k < 32; k++) wr_reg(5'(k), 32'(k) * 32'h11);
        bus.i_DumpReady = 1'b1;
        bus.i_DumpStart = 1'b1;
        fv = 0; dn = 0; dc = 0; words = 0; d31 = '0;
        for (int n = 1; n <= 80; n++) begin
            tick();
            bus.i_DumpStart = 1'b0;
            if (n == 1) chk("busy_lit", 32'(bus.o_DumpBusy), 1);
            if (bus.o_DumpValid) begin
                words++;
                if (fv == 0) fv = n;
                if (bus.o_DumpAddr == 5'd31) d31 = bus.o_DumpData;
            end
            if (bus.o_DumpDone) begin
                dc++;
                dn = n;
            end
        end
        chk("first_valid_lat", 32'(fv), 2);
        chk("done_lat", 32'(dn), 65);
        chk("done_count", 32'(dc), 1);
        chk("word_count", 32'(words), 32);
        chk("r31_data_lit", d31, 32'h20F);
        chk("busy_after", 32'(bus.o_DumpBusy), 0);

        // Backpressure at addr 3 with a write and a second start
        bus.i_DumpStart = 1'b1;
        wait_addr(5'd3, found);
        bus.i_DumpReady = 1'b0;
        chk("addr3_seen", 32'(found), 1);
        chk("addr3_data_lit", bus.o_DumpData, 32'h33);
        for (int s = 0; s < 10; s++) begin
            if (s == 2) begin
                bus.i_RegWrite  = 1'b1;
                bus.i_WriteReg  = 5'd3;
                bus.i_WriteData = 32'hFFFF0000;
            end
            if (s == 5) bus.i_DumpStart = 1'b1;
            tick();
            bus.i_RegWrite  = 1'b0;
            bus.i_DumpStart = 1'b0;
        end
        chk("stall_data_lit", bus.o_DumpData, 32'h33);
        chk("stall_valid", 32'(bus.o_DumpValid), 1);
        chk("stall_addr", 32'(bus.o_DumpAddr), 3);
        bus.i_rs = 5'd3;
        #1 chk("r3_new_lit", bus.o_ReadData1, 32'hFFFF0000);
        bus.i_DumpReady = 1'b1;
        wait_done(found);
        chk("bp_done_seen", 32'(found), 1);
        for (int n = 0; n < 5; n++) tick();
        chk("no_restart_busy", 32'(bus.o_DumpBusy), 0);
        chk("no_restart_valid", 32'(bus.o_DumpValid), 0);

        // Reset in the middle of a dump
        bus.i_DumpStart = 1'b1;
        wait_addr(5'd5, found);
        chk("addr5_seen", 32'(found), 1);
        bus.i_DumpReady = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.o_DumpValid), 0);
        chk("abort_busy", 32'(bus.o_DumpBusy), 0);
        chk("abort_data", bus.o_DumpData, 0);
        bus.i_rs = 5'd8;
        #1 chk("abort_r8_lit", bus.o_ReadData1, 0);
        tick();
        rst = 1'b0;
        tick();
        bus.i_DumpReady = 1'b1;
        bus.i_DumpStart = 1'b1;
        wait_addr(5'd0, found);
        chk("restart_seen", 32'(found), 1);
        chk("restart_addr", 32'(bus.o_DumpAddr), 0);
        chk("restart_data", bus.o_DumpData, 0);
        wait_done(found);
        chk("restart_done", 32'(found), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
